// File: rtl/sar_comp_search_if.sv
// Handshake/bus bundle between the SAR search controller and its environment.
//   slave  : controller side (takes start and comparator response, drives candidate/result)
//   master : environment side (drives start and comparator response, observes outputs)
interface sar_comp_search_if #(
  parameter int unsigned N = 8
);
  logic         i_Start;
  logic         i_Mayor;
  logic         i_Igual;
  logic         i_Menor;
  logic [N-1:0] o_Cand;
  logic         o_Busy;
  logic         o_Done;
  logic [N-1:0] o_Result;
  logic         o_Exact;
  logic         o_Err;

  modport slave (
    input  i_Start, i_Mayor, i_Igual, i_Menor,
    output o_Cand, o_Busy, o_Done, o_Result, o_Exact, o_Err
  );

  modport master (
    output i_Start, i_Mayor, i_Igual, i_Menor,
    input  o_Cand, o_Busy, o_Done, o_Result, o_Exact, o_Err
  );
endinterface

// File: rtl/sar_comp_search.sv
// Successive-approximation search driven by an external comparator with
// fixed latency LAT. Each bit is held for LAT+1 cycles before its response
// is sampled; an equality response terminates the search early.
// Ports:
//   i_Clk    : clock, rising edge
//   i_Rst_n  : asynchronous active-low reset
//   bus      : sar_comp_search_if.slave
//     i_Start               start request (IDLE only)
//     i_Mayor/i_Igual/i_Menor comparator response (cand >, ==, < target)
//     o_Cand                candidate word to comparator
//     o_Busy                search in progress
//     o_Done                one-cycle result-valid pulse
//     o_Result              result, held until next start
//     o_Exact               equality observed
//     o_Err                 comparator response was not one-hot
module sar_comp_search #(
  parameter int unsigned N   = 8,
  parameter int unsigned LAT = 2
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  sar_comp_search_if.slave  bus
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [N-1:0]    r_cand, w_cand;
  logic [N-1:0]    r_result, w_result;
  logic [IW-1:0]   r_idx, w_idx;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            r_exact, w_exact;
  logic            r_err, w_err;

  logic [2:0]      w_resp;
  logic            w_onehot;
  logic            w_sample;
  logic            w_last;
  logic [N-1:0]    w_cand_upd;

  assign w_resp   = {bus.i_Mayor, bus.i_Igual, bus.i_Menor};
  assign w_onehot = (w_resp == 3'b100) || (w_resp == 3'b010) || (w_resp == 3'b001);
  // Response is valid on the (LAT+1)-th edge after the candidate changed
  assign w_sample = (r_state == S_WAIT) && (r_cnt == CW'(LAT));
  assign w_last   = (r_idx == '0);

  // State and datapath registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state  <= S_IDLE;
      r_cand   <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_exact  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cand   <= w_cand;
      r_result <= w_result;
      r_idx    <= w_idx;
      r_cnt    <= w_cnt;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_exact  <= w_exact;
      r_err    <= w_err;
    end
  end

  // Next-state logic
  always_comb begin
    w_state = r_state;
    case (r_state)
      S_IDLE: if (bus.i_Start) w_state = S_WAIT;
      S_WAIT: if (w_sample && (!w_onehot || bus.i_Igual || w_last)) w_state = S_DONE;
      S_DONE: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and search datapath
  always_comb begin
    w_cand     = r_cand;
    w_result   = r_result;
    w_idx      = r_idx;
    w_cnt      = r_cnt;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_exact    = r_exact;
    w_err      = r_err;
    // Candidate with the current bit resolved by a "greater" response
    w_cand_upd = r_cand;
    if (bus.i_Mayor) w_cand_upd[r_idx] = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.i_Start) begin
          w_cand        = '0;
          w_cand[N-1]   = 1'b1;
          w_idx         = IW'(N - 1);
          w_cnt         = '0;
          w_exact       = 1'b0;
          w_err         = 1'b0;
          w_busy        = 1'b1;
        end
      end
      S_WAIT: begin
        if (!w_sample) begin
          w_cnt = r_cnt + CW'(1);
        end else if (!w_onehot) begin
          w_err    = 1'b1;
          w_result = r_cand;
          w_busy   = 1'b0;
          w_done   = 1'b1;
        end else if (bus.i_Igual) begin
          w_result = r_cand;
          w_exact  = 1'b1;
          w_busy   = 1'b0;
          w_done   = 1'b1;
        end else if (w_last) begin
          w_cand   = w_cand_upd;
          w_result = w_cand_upd;
          w_exact  = 1'b0;
          w_busy   = 1'b0;
          w_done   = 1'b1;
        end else begin
          // Resolve current bit and trial-set the next lower one
          w_cand                   = w_cand_upd;
          w_cand[r_idx - IW'(1)]   = 1'b1;
          w_idx                    = r_idx - IW'(1);
          w_cnt                    = '0;
        end
      end
      S_DONE: w_busy = 1'b0;
      default: ;
    endcase
  end

  assign bus.o_Cand   = r_cand;
  assign bus.o_Result = r_result;
  assign bus.o_Busy   = r_busy;
  assign bus.o_Done   = r_done;
  assign bus.o_Exact  = r_exact;
  assign bus.o_Err    = r_err;

endmodule

// File: tb/tb_sar_comp_search.sv
// Scoreboard bench: three controllers (LAT=1,2,4) share start/target and each
// sees its own registered comparator model with matching latency.
module tb_sar_comp_search;
  localparam int unsigned N = 8;
  localparam int L0 = 1;
  localparam int L1 = 2;
  localparam int L2 = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] target;
  int         bad_mode;
  int         cyc = 0;
  int         st_cyc = 0;
  int         n_total = 0;
  int         n_bad = 0;

  typedef struct {
    logic [7:0] res;
    logic       exact;
    logic       err;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e0, e1, e2, last1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sar_comp_search_if #(.N(N)) if0 ();
  sar_comp_search_if #(.N(N)) if1 ();
  sar_comp_search_if #(.N(N)) if2 ();

  sar_comp_search #(.N(N), .LAT(L0)) dut0 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(if0));
  sar_comp_search #(.N(N), .LAT(L1)) dut1 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(if1));
  sar_comp_search #(.N(N), .LAT(L2)) dut2 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(if2));

  // Registered comparator pipelines, one stage per latency cycle
  logic [7:0] p0 [1];
  logic [7:0] p1 [2];
  logic [7:0] p2 [4];
  always @(posedge clk) begin
    p0[0] <= if0.o_Cand;
    p1[0] <= if1.o_Cand;
    p1[1] <= p1[0];
    p2[0] <= if2.o_Cand;
    for (int i = 1; i < 4; i++) p2[i] <= p2[i-1];
  end

  logic [7:0] c0, c1, c2;
  assign c0 = p0[0];
  assign c1 = p1[1];
  assign c2 = p2[3];

  assign if0.i_Start = start;
  assign if1.i_Start = start;
  assign if2.i_Start = start;
  assign if0.i_Mayor = (bad_mode == 0) ? (c0 > target)  : (bad_mode == 1);
  assign if0.i_Menor = (bad_mode == 0) ? (c0 < target)  : (bad_mode == 1);
  assign if0.i_Igual = (bad_mode == 0) ? (c0 == target) : 1'b0;
  assign if1.i_Mayor = (bad_mode == 0) ? (c1 > target)  : (bad_mode == 1);
  assign if1.i_Menor = (bad_mode == 0) ? (c1 < target)  : (bad_mode == 1);
  assign if1.i_Igual = (bad_mode == 0) ? (c1 == target) : 1'b0;
  assign if2.i_Mayor = (bad_mode == 0) ? (c2 > target)  : (bad_mode == 1);
  assign if2.i_Menor = (bad_mode == 0) ? (c2 < target)  : (bad_mode == 1);
  assign if2.i_Igual = (bad_mode == 0) ? (c2 == target) : 1'b0;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d act=%0h exp=%0h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  task automatic chk_out(input int d, input exp_t e, input logic [7:0] res,
                         input logic exact, input logic err, input logic busy);
    chk("result",       d, res,            e.res);
    chk("exact",        d, exact,          e.exact);
    chk("err",          d, err,            e.err);
    chk("latency",      d, cyc - st_cyc,   e.lat);
    chk("busy_at_done", d, busy,           0);
  endtask

  task automatic unexpected(input int d);
    n_total++;
    n_bad++;
    $display("FAIL unexpected_done dut%0d act=1 exp=0 (t=%0t)", d, $time);
  endtask

  // Monitors: pop and compare whenever a controller pulses o_Done
  always @(negedge clk) if (if0.o_Done) begin
    if (q0.size() == 0) unexpected(0);
    else begin e0 = q0.pop_front(); chk_out(0, e0, if0.o_Result, if0.o_Exact, if0.o_Err, if0.o_Busy); end
  end
  always @(negedge clk) if (if1.o_Done) begin
    if (q1.size() == 0) unexpected(1);
    else begin e1 = q1.pop_front(); chk_out(1, e1, if1.o_Result, if1.o_Exact, if1.o_Err, if1.o_Busy); end
  end
  always @(negedge clk) if (if2.o_Done) begin
    if (q2.size() == 0) unexpected(2);
    else begin e2 = q2.pop_front(); chk_out(2, e2, if2.o_Result, if2.o_Exact, if2.o_Err, if2.o_Busy); end
  end

  // Reference: plain binary search counting probes; bad comparator ends at first probe
  function automatic exp_t model(input logic [7:0] t, input int lat, input int mode);
    exp_t e;
    logic [7:0] lo, p;
    int probes;
    bit hit;
    if (mode != 0) begin
      e.res = 8'h80; e.exact = 1'b0; e.err = 1'b1; e.lat = lat + 1;
      return e;
    end
    lo = 8'h00; probes = 0; hit = 1'b0;
    for (int b = 7; b >= 0; b--) begin
      if (!hit) begin
        p = lo | (8'd1 << b);
        probes++;
        if (p == t) hit = 1'b1;
        else if (p < t) lo = p;
      end
    end
    e.res = hit ? t : lo; e.exact = hit; e.err = 1'b0; e.lat = probes * (lat + 1);
    return e;
  endfunction

  task automatic chk_zero(input int d, input logic [7:0] cand, input logic [7:0] res,
                          input logic busy, input logic done, input logic exact, input logic err);
    chk("rst_cand",  d, cand,  0);
    chk("rst_result",d, res,   0);
    chk("rst_busy",  d, busy,  0);
    chk("rst_done",  d, done,  0);
    chk("rst_exact", d, exact, 0);
    chk("rst_err",   d, err,   0);
  endtask

  task automatic zero_all();
    chk_zero(0, if0.o_Cand, if0.o_Result, if0.o_Busy, if0.o_Done, if0.o_Exact, if0.o_Err);
    chk_zero(1, if1.o_Cand, if1.o_Result, if1.o_Busy, if1.o_Done, if1.o_Exact, if1.o_Err);
    chk_zero(2, if2.o_Cand, if2.o_Result, if2.o_Busy, if2.o_Done, if2.o_Exact, if2.o_Err);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL timeout pending=%0d exp=0", q0.size() + q1.size() + q2.size());
      q0.delete(); q1.delete(); q2.delete();
    end
  endtask

  // Issue one search; optional second start at edge 5; after_rst starts on release
  task automatic run(input logic [7:0] t, input int mode, input bit dbl, input bit after_rst);
    target   = t;
    bad_mode = mode;
    q0.push_back(model(t, L0, mode));
    q1.push_back(model(t, L1, mode));
    last1 = model(t, L1, mode);
    q2.push_back(model(t, L2, mode));
    if (!after_rst) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    st_cyc = cyc;
    chk("busy_start", 1, if1.o_Busy, 1);
    chk("cand_start", 0, if0.o_Cand, 8'h80);
    chk("cand_start", 2, if2.o_Cand, 8'h80);
    if (dbl) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_idle();
    #1;
    chk("done_pulse_len", 1, if1.o_Done,   0);
    chk("result_held",    1, if1.o_Result, last1.res);
    chk("exact_held",     1, if1.o_Exact,  last1.exact);
    bad_mode = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    target   = 8'h00;
    bad_mode = 0;
    #1;
    zero_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run(8'h5A, 0, 1'b0, 1'b0);
    run(8'h00, 0, 1'b0, 1'b0);
    run(8'hFF, 0, 1'b0, 1'b0);
    run(8'h5A, 1, 1'b0, 1'b0);
    run(8'h5A, 2, 1'b0, 1'b0);
    run(8'h5A, 0, 1'b1, 1'b0);

    // Abort mid-search with reset: outputs clear without a clock, no done pulse
    target = 8'h5A;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    zero_all();
    repeat (2) @(posedge clk);
    #1;
    run(8'h5A, 0, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run(8'($urandom_range(0, 255)), 0, 1'b0, 1'b0);
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
